// File: rtl/bcd_pkg.sv
// Shared types and helpers for the packed-BCD counter.
// - bcd_digit_t : one BCD nibble
// - BCD_MAX/MIN : digit range limits
// - is_bcd()    : true when a nibble is a legal BCD digit
// - op_e        : per-edge operation chosen by the priority mux
package bcd_pkg;
    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_CLR  = 2'd1,
        OP_LOAD = 2'd2,
        OP_STEP = 2'd3
    } op_e;

    function automatic logic is_bcd(input bcd_digit_t nibble);
        return nibble <= BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_counter_n_if.sv
// Request/status bundle for bcd_counter_n.
// - master : drives clr, load, load_val, en, up; observes count, tc, load_err
// - slave  : the counter side
interface bcd_counter_n_if #(
    parameter int DIGITS = 3
);
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  en;
    logic                  up;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic                  load_err;

    modport master (
        output clr, load, load_val, en, up,
        input  count, tc, load_err
    );

    modport slave (
        input  clr, load, load_val, en, up,
        output count, tc, load_err
    );
endinterface

// File: rtl/bcd_digit.sv
// One BCD digit of the ripple carry/borrow chain (purely combinational).
// - d    : current digit value
// - step : counter is taking a step this cycle
// - up   : 1 increment, 0 decrement
// - ci   : every lower digit is at its limit (9 going up, 0 going down)
// - nxt  : digit value after this cycle
// - co   : this digit and every lower digit are at the limit
module bcd_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    input  logic       step,
    input  logic       up,
    input  logic       ci,
    output bcd_digit_t nxt,
    output logic       co
);
    logic at_lim;

    assign at_lim = up ? (d == BCD_MAX) : (d == BCD_MIN);
    assign co     = ci & at_lim;

    always_comb begin
        nxt = d;
        if (step && ci) begin
            if (up) nxt = at_lim ? BCD_MIN : d + 4'd1;
            else    nxt = at_lim ? BCD_MAX : d - 4'd1;
        end
    end
endmodule

// File: rtl/bcd_counter_n.sv
// N-digit packed-BCD up/down counter with clear, validated load and
// terminal-count pulse. Priority per edge: clr > load > en.
// - clk, rst_n : clock, asynchronous active-low reset
// - bus        : slave side of bcd_counter_n_if (requests in, count/tc/load_err out)
// WRAP=1 rolls over at all-9s / zero; WRAP=0 holds at the boundary. tc
// pulses for the cycle after any step taken from a boundary value, which in
// saturate mode repeats on every enabled cycle held at the boundary.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter bit WRAP   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_counter_n_if.slave  bus
);
    logic [DIGITS-1:0][3:0] count_q;
    logic [DIGITS-1:0][3:0] count_nxt;
    logic [DIGITS-1:0][3:0] load_digits;
    logic [DIGITS:0]        chain;
    logic                   boundary;
    logic                   step;
    logic                   load_ok;
    logic                   tc_q;
    logic                   load_err_q;
    op_e                    op;

    // chain[i] = all digits below i are at the limit for the current direction;
    // chain[DIGITS] therefore means the whole count sits at the range end.
    assign chain[0]  = 1'b1;
    assign boundary  = chain[DIGITS];
    // In saturate mode the step is suppressed at the boundary so every digit holds.
    assign step      = bus.en & (WRAP | ~boundary);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .d    (count_q[g]),
            .step (step),
            .up   (bus.up),
            .ci   (chain[g]),
            .nxt  (count_nxt[g]),
            .co   (chain[g+1])
        );
    end

    assign load_digits = bus.load_val;

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (!is_bcd(load_digits[i])) load_ok = 1'b0;
    end

    always_comb begin
        op = OP_HOLD;
        if (bus.clr)       op = OP_CLR;
        else if (bus.load) op = OP_LOAD;
        else if (bus.en)   op = OP_STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
            case (op)
                OP_CLR:  count_q <= '0;
                OP_LOAD: begin
                    if (load_ok) count_q    <= load_digits;
                    else         load_err_q <= 1'b1;
                end
                OP_STEP: begin
                    count_q <= count_nxt;
                    tc_q    <= boundary;
                end
                default: ;
            endcase
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = tc_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed-vector bench: a wrapping and a saturating 3-digit counter share
// the same stimulus; each table row carries the expected result for both.
module tb_bcd_counter_n;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, load, en, up;
    logic [11:0] load_val;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_counter_n_if #(.DIGITS(3)) bw ();
    bcd_counter_n_if #(.DIGITS(3)) bs ();

    assign bw.clr = clr;  assign bw.load = load;  assign bw.load_val = load_val;
    assign bw.en  = en;   assign bw.up   = up;
    assign bs.clr = clr;  assign bs.load = load;  assign bs.load_val = load_val;
    assign bs.en  = en;   assign bs.up   = up;

    bcd_counter_n #(.DIGITS(3), .WRAP(1'b1)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bw.slave));
    bcd_counter_n #(.DIGITS(3), .WRAP(1'b0)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs.slave));

    typedef struct {
        logic        clr, load;
        logic [11:0] lv;
        logic        en, up;
        logic [11:0] wc;  logic wt;
        logic [11:0] sc;  logic st;
        logic        err;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t v(logic c, logic l, logic [11:0] lv, logic e, logic u,
                               logic [11:0] wc, logic wt, logic [11:0] sc, logic st, logic err);
        vec_t r;
        r.clr = c; r.load = l; r.lv = lv; r.en = e; r.up = u;
        r.wc = wc; r.wt = wt; r.sc = sc; r.st = st; r.err = err;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [11:0] wc, input logic wt,
                           input logic [11:0] sc, input logic st, input logic err);
        chk("w_count", idx, bw.count, wc);
        chk("w_tc",    idx, {11'd0, bw.tc}, {11'd0, wt});
        chk("w_err",   idx, {11'd0, bw.load_err}, {11'd0, err});
        chk("s_count", idx, bs.count, sc);
        chk("s_tc",    idx, {11'd0, bs.tc}, {11'd0, st});
        chk("s_err",   idx, {11'd0, bs.load_err}, {11'd0, err});
    endtask

    initial begin
        //            clr load lv      en up  w_cnt   wt  s_cnt   st  err
        tbl[0]  = v(0, 1, 12'h998, 0, 0, 12'h998, 0, 12'h998, 0, 0);
        tbl[1]  = v(0, 0, 12'h000, 1, 1, 12'h999, 0, 12'h999, 0, 0);
        tbl[2]  = v(0, 0, 12'h000, 1, 1, 12'h000, 1, 12'h999, 1, 0);
        tbl[3]  = v(0, 0, 12'h000, 1, 1, 12'h001, 0, 12'h999, 1, 0);
        tbl[4]  = v(0, 1, 12'h100, 0, 0, 12'h100, 0, 12'h100, 0, 0);
        tbl[5]  = v(0, 0, 12'h000, 1, 0, 12'h099, 0, 12'h099, 0, 0);
        tbl[6]  = v(0, 1, 12'h099, 0, 0, 12'h099, 0, 12'h099, 0, 0);
        tbl[7]  = v(0, 0, 12'h000, 1, 1, 12'h100, 0, 12'h100, 0, 0);
        tbl[8]  = v(0, 1, 12'h3A5, 0, 0, 12'h100, 0, 12'h100, 0, 1);
        tbl[9]  = v(0, 0, 12'h000, 0, 0, 12'h100, 0, 12'h100, 0, 0);
        tbl[10] = v(0, 1, 12'h385, 0, 0, 12'h385, 0, 12'h385, 0, 0);
        tbl[11] = v(0, 1, 12'h512, 0, 0, 12'h512, 0, 12'h512, 0, 0);
        tbl[12] = v(1, 1, 12'h777, 1, 1, 12'h000, 0, 12'h000, 0, 0);
        tbl[13] = v(0, 1, 12'h512, 0, 0, 12'h512, 0, 12'h512, 0, 0);
        tbl[14] = v(0, 1, 12'h777, 1, 1, 12'h777, 0, 12'h777, 0, 0);
        tbl[15] = v(0, 0, 12'h000, 1, 0, 12'h776, 0, 12'h776, 0, 0);
        tbl[16] = v(0, 1, 12'h000, 0, 0, 12'h000, 0, 12'h000, 0, 0);
        tbl[17] = v(0, 0, 12'h000, 1, 0, 12'h999, 1, 12'h000, 1, 0);
        tbl[18] = v(0, 0, 12'h000, 0, 0, 12'h999, 0, 12'h000, 0, 0);
        tbl[19] = v(0, 1, 12'h9A9, 0, 0, 12'h999, 0, 12'h000, 0, 1);
        tbl[20] = v(0, 0, 12'h000, 1, 0, 12'h998, 0, 12'h000, 1, 0);
        tbl[21] = v(0, 0, 12'h000, 1, 1, 12'h999, 0, 12'h001, 0, 0);
        tbl[22] = v(0, 1, 12'h001, 0, 0, 12'h001, 0, 12'h001, 0, 0);
        tbl[23] = v(0, 0, 12'h000, 1, 0, 12'h000, 0, 12'h000, 0, 0);
        tbl[24] = v(0, 0, 12'h000, 1, 0, 12'h999, 1, 12'h000, 1, 0);
        tbl[25] = v(0, 0, 12'h000, 1, 0, 12'h998, 0, 12'h000, 1, 0);

        rst_n = 1'b0; clr = 0; load = 0; load_val = '0; en = 0; up = 0;
        repeat (2) @(posedge clk);
        #1 chk_all(-1, 12'h000, 0, 12'h000, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            clr = tbl[i].clr; load = tbl[i].load; load_val = tbl[i].lv;
            en  = tbl[i].en;  up   = tbl[i].up;
            @(posedge clk);
            #1 chk_all(i, tbl[i].wc, tbl[i].wt, tbl[i].sc, tbl[i].st, tbl[i].err);
        end

        // Async reset mid-count at 457, then restart counting up from zero.
        clr = 0; load = 1; load_val = 12'h457; en = 0; up = 0;
        @(posedge clk);
        #1 chk_all(100, 12'h457, 0, 12'h457, 0, 0);
        load = 0; en = 1; up = 1;
        #2 rst_n = 1'b0;
        #1 chk_all(101, 12'h000, 0, 12'h000, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk_all(102, 12'h001, 0, 12'h001, 0, 0);
        en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
